load_store_unit: RTL and testbench

- Sits between the core's execute stage and the word-wide data RAM, directly upstream of the RAM.
- The data RAM has a single port, is word-addressed, writes synchronously on clock and reads combinationally when wread is asserted.
- This block turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM cycles:
  - lane extraction and sign/zero extension on loads;
  - read-modify-write for sub-word stores;
  - misalignment and illegal-width detection.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/ls_align.sv | 49 ++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the access legality rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    FIN    = 3'd4
  } lsu_state_t;

  // Unsigned widths exist only for loads; halves need even, words need 4-aligned offsets.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = (off[0] == 1'b0);
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ls_align.sv
// Byte-lane datapath: load extraction/extension, sub-word store merge and
// legality of the requested access.
module ls_align
  import lsu_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [size-1:0] i_word,
  input  logic [size-1:0] i_wdata,
  output logic [size-1:0] o_load,
  output logic [size-1:0] o_merged,
  output logic            o_legal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte  = i_word[{i_off, 3'b000} +: 8];
  assign w_half  = i_word[{i_off[1], 4'b0000} +: 16];
  assign o_legal = lsu_legal(i_we, i_funct3, i_off);

  // Load value: selected lane, sign- or zero-extended.
  always_comb begin
    o_load = '0;
    case (i_funct3)
      F3_B:    o_load = {{(size-8){w_byte[7]}}, w_byte};
      F3_H:    o_load = {{(size-16){w_half[15]}}, w_half};
      F3_W:    o_load = i_word;
      F3_BU:   o_load = {{(size-8){1'b0}}, w_byte};
      F3_HU:   o_load = {{(size-16){1'b0}}, w_half};
      default: o_load = '0;
    endcase
  end

  // Store word: RAM word with the addressed lane replaced by the low store data.
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      F3_W:    o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a single-port, word-wide data RAM
// with combinational read; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int mem_depth = 1024,
  parameter  int size      = 32,
  localparam int AW        = $clog2(mem_depth)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [size-1:0] addr,
  input  logic [size-1:0] wdata,
  output logic [size-1:0] rdata,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic [AW-1:0]   mem_addr,
  output logic [size-1:0] mem_data,
  output logic            mem_wren,
  output logic            mem_wread,
  input  logic [size-1:0] mem_salida
);

  lsu_state_t      r_state, w_next;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic [AW-1:0]   r_waddr;
  logic [size-1:0] r_wdata;
  logic [size-1:0] r_rdata;
  logic            r_err;

  logic            w_idle;
  logic            w_accept;
  logic            w_sel_we;
  logic [2:0]      w_sel_f3;
  logic [1:0]      w_sel_off;
  logic [size-1:0] w_load;
  logic [size-1:0] w_merged;
  logic            w_legal;
  logic            w_unused_addr;

  assign w_idle        = (r_state == IDLE);
  assign w_accept      = w_idle & req;
  assign w_unused_addr = ^addr[size-1:AW+2];

  // Legality is judged on the live request in IDLE; the datapath uses the latched one later.
  assign w_sel_we  = w_idle ? we          : r_we;
  assign w_sel_f3  = w_idle ? funct3      : r_f3;
  assign w_sel_off = w_idle ? addr[1:0]   : r_off;

  ls_align #(.size(size)) u_align (
    .i_we     (w_sel_we),
    .i_funct3 (w_sel_f3),
    .i_off    (w_sel_off),
    .i_word   (mem_salida),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged),
    .o_legal  (w_legal)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!req) begin
          w_next = IDLE;
        end else if (!w_legal) begin
          w_next = FIN;
        end else if (!we) begin
          w_next = LOAD;
        end else if (funct3 == F3_W) begin
          w_next = WRITE;
        end else begin
          w_next = RMW_RD;
        end
      end
      LOAD:    w_next = FIN;
      RMW_RD:  w_next = WRITE;
      WRITE:   w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, merge capture and load result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= we;
      r_f3    <= funct3;
      r_off   <= addr[1:0];
      r_waddr <= addr[AW+1:2];
      r_wdata <= wdata;
      r_err   <= ~w_legal;
      if (!w_legal) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= r_rdata;
      end
    end else if (r_state == LOAD) begin
      r_rdata <= w_load;
    end else if (r_state == RMW_RD) begin
      r_wdata <= w_merged;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // Memory strobes come straight from the state so reset kills them asynchronously.
  assign busy      = ~w_idle;
  assign done      = (r_state == FIN);
  assign err       = done & r_err;
  assign rdata     = r_rdata;
  assign mem_addr  = r_waddr;
  assign mem_wread = (r_state == LOAD) | (r_state == RMW_RD);
  assign mem_wren  = (r_state == WRITE);
  assign mem_data  = mem_wren ? r_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit against a behavioural
// single-port RAM.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        mem_wread;
  logic [31:0] mem_salida;

  logic [31:0] ram [0:1023] = '{default: 32'h0};

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] mdata;
    logic [9:0]  maddr;
  } exp_t;

  exp_t sb[$];

  load_store_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_wread  (mem_wread),
    .mem_salida (mem_salida)
  );

  always #5 clock = ~clock;

  assign mem_salida = mem_wread ? ram[mem_addr] : 32'h0;

  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntotal++;
    assert (obs === exp_v) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic access(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input int nrd, input int nwr,
                        input logic [31:0] mdata, input logic [9:0] maddr);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          rdc;
    int          wrc;
    logic [31:0] md_seen;
    logic [9:0]  ma_seen;
    bit          seen;
    e = '{tag, exp_rd, exp_err, lat, nrd, nwr, mdata, maddr};
    sb.push_back(e);
    @(negedge clock);
    chk({tag, " busy_before"}, {31'b0, busy}, 32'h0);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    cyc = 0; rdc = 0; wrc = 0; md_seen = 32'h0; ma_seen = 10'h0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clock);
      cyc++;
      if (mem_wread) begin rdc++; ma_seen = mem_addr; end
      if (mem_wren)  begin wrc++; md_seen = mem_data; ma_seen = mem_addr; end
      if (done) seen = 1'b1;
    end
    chk({tag, " done_seen"}, {31'b0, seen}, 32'h1);
    got = sb.pop_front();
    if (seen) begin
      chk({got.tag, " latency"}, cyc, got.lat);
      chk({got.tag, " err"}, {31'b0, err}, {31'b0, got.err});
      chk({got.tag, " rdata"}, rdata, got.rdata);
      chk({got.tag, " wread_cycles"}, rdc, got.nrd);
      chk({got.tag, " wren_cycles"}, wrc, got.nwr);
      if (got.nrd + got.nwr > 0) chk({got.tag, " mem_addr"}, {22'b0, ma_seen}, {22'b0, got.maddr});
      if (got.nwr > 0) chk({got.tag, " mem_data"}, md_seen, got.mdata);
    end
    // req is still high across the FIN edge: it must not start another access.
    @(negedge clock);
    chk({tag, " no_accept_in_fin"}, {30'b0, busy, done}, 32'h0);
    req = 1'b0;
  endtask

  initial begin
    int extra_done;
    reset_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clock);
    chk("reset rdata", rdata, 32'h0);
    chk("reset flags", {28'b0, done, err, busy, mem_wren}, 32'h0);
    chk("reset mem_wread", {31'b0, mem_wread}, 32'h0);
    chk("reset mem_addr", {22'b0, mem_addr}, 32'h0);
    chk("reset mem_data", mem_data, 32'h0);
    reset_n = 1'b1;

    access("SW 0x10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF, 10'd4);
    chk("ram4 after SW", ram[4], 32'hDEADBEEF);
    access("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("LHU 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("SB 0x11",  1'b1, 3'b000, 32'h11, 32'h12345677, 32'h0000DEAD, 1'b0, 3, 1, 1, 32'hDEAD77EF, 10'd4);
    access("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("SH 0x12",  1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'hDEAD77EF, 1'b0, 3, 1, 1, 32'hCAFE77EF, 10'd4);
    access("LW after SH", 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE77EF, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("LW misaligned", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 10'd0);
    access("LW reload", 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE77EF, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("LH misaligned", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 10'd0);
    access("LBU 0x10", 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0, 2, 1, 0, 32'h0, 10'd4);
    access("funct3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 10'd0);
    access("store funct3 100", 1'b1, 3'b100, 32'h10, 32'h55555555, 32'h0, 1'b1, 1, 0, 0, 32'h0, 10'd0);
    chk("ram4 after errors", ram[4], 32'hCAFE77EF);
    access("LW wrap 0x1010", 1'b0, 3'b010, 32'h1010, 32'h0, 32'hCAFE77EF, 1'b0, 2, 1, 0, 32'h0, 10'd4);

    // Abort a word store while it is in its WRITE cycle.
    @(negedge clock);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hA5A5A5A5;
    @(negedge clock);
    chk("abort in WRITE", {31'b0, mem_wren}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("abort wren drops", {31'b0, mem_wren}, 32'h0);
    chk("abort busy drops", {31'b0, busy}, 32'h0);
    req = 1'b0;
    extra_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) extra_done++;
    end
    chk("abort no done", extra_done, 32'h0);
    chk("abort ram8", ram[8], 32'h0);
    chk("abort rdata cleared", rdata, 32'h0);
    reset_n = 1'b1;
    access("LW 0x20 after abort", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 2, 1, 0, 32'h0, 10'd8);
    access("LH 0x10 after abort", 1'b0, 3'b001, 32'h10, 32'h0, 32'h000077EF, 1'b0, 2, 1, 0, 32'h0, 10'd4);

    chk("scoreboard drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
